iter_muldiv_unit: RTL and testbench

ITER_MULDIV_UNIT -- requirements
Module: iter_muldiv_unit

---
 rtl/iter_muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
//==============================================================================
// Module      : iter_muldiv_unit
// Description : Iterative radix-2 multiply / divide unit. Shift-add multiply
//               and restoring divide, one bit per cycle, with a final sign
//               fix-up cycle. Results are published only on entry to DONE.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module iter_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                     c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]       c_one_w    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]     c_one_2w   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 op_div_q, op_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    // Multiply: {product hi, product lo / remaining multiplier bits}
    // Divide  : low half holds dividend bits shifting out / quotient shifting in
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Divide partial remainder (always below the divisor, so WIDTH bits hold it;
    // the trial subtraction below works on WIDTH+1 bits)
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    // Operand conditioning at the start handshake
    logic                 w_signed_op;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_b_zero;

    // One iteration of each algorithm
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_qbit;

    // Sign fix-up results
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Operand sign extraction and magnitude conversion
    always_comb begin
        w_signed_op = SIGNED_EN && op[1];
        w_sign_a    = w_signed_op & a[WIDTH-1];
        w_sign_b    = w_signed_op & b[WIDTH-1];
        w_mag_a     = w_sign_a ? (~a + c_one_w) : a;
        w_mag_b     = w_sign_b ? (~b + c_one_w) : b;
        w_b_zero    = (b == '0);
    end

    // Datapath: one shift-add step, one restoring-divide step, and the sign fix-up
    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        w_mul_next  = {w_mul_sum, acc_q[WIDTH-1:1]};

        w_div_shift = {rem_q, acc_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, opnd_q};
        w_div_qbit  = ~w_div_diff[WIDTH];

        w_prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + c_one_2w) : acc_q;
        w_quo_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + c_one_w)
                                            : acc_q[WIDTH-1:0];
        w_rem_fix   = sign_a_q ? (~rem_q + c_one_w) : rem_q;
    end

    // Next-state and register update logic for the IDLE/RUN/FIX/DONE sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_div_d = op[0];
                    sign_a_d = w_sign_a;
                    sign_b_d = w_sign_b;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    rem_d    = '0;
                    if (op[0] && w_b_zero) begin
                        // Divide by zero short-circuits straight to DONE
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        opnd_d  = op[0] ? w_mag_b : w_mag_a;
                        acc_d   = {{WIDTH{1'b0}}, (op[0] ? w_mag_a : w_mag_b)};
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_div_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_div_qbit};
                    rem_d = w_div_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                end else begin
                    acc_d = w_mul_next;
                end
                cnt_d = cnt_q + c_cnt_one;
                if (cnt_q == c_cnt_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Status outputs decode directly from the state register
    always_comb begin
        busy        = (state_q == S_RUN) || (state_q == S_FIX);
        done        = (state_q == S_DONE);
        hi          = hi_q;
        lo          = lo_q;
        div_by_zero = dbz_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv_unit.sv
//==============================================================================
// Module      : tb_iter_muldiv_unit
// Description : Self-checking bench for iter_muldiv_unit (WIDTH=32, signed
//               enabled) against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iter_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clock;
    logic             clear;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    int n_total;
    int n_bad;

    iter_muldiv_unit #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (1'b1)
    ) u_dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the operands
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sx, sy, ux, uy, q, r;
        logic [63:0] p;
        sx = longint'({{32{x[31]}}, x});
        sy = longint'({{32{y[31]}}, y});
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ed = 1'b0;
        if (!o[0]) begin
            p  = o[1] ? 64'(sx * sy) : 64'(ux * uy);
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else begin
            if (o[1]) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = ux / uy;
                r = ux % uy;
            end
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    // One full operation: launch, optional re-pulse of start while busy,
    // wait (bounded) for done, then check latency and results
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit repulse);
        logic [31:0] eh, el, ph, pl;
        logic        ed;
        int          edges;
        bit          seen;
        model(o, x, y, eh, el, ed);
        ph = hi;
        pl = lo;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        seen = 1'b0;
        edges = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (edges == 0) begin
                check_val("busy_after_start", 64'(busy), 64'd1);
                check_val("dbz_cleared", 64'(div_by_zero), 64'd0);
            end
            if (edges == 4 && repulse) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 32'd3;
            end
            if (edges == 5) start = 1'b0;
            if (edges == 10) begin
                check_val("hi_hold", 64'(hi), 64'(ph));
                check_val("lo_hold", 64'(lo), 64'(pl));
            end
            @(negedge clock);
            edges++;
        end
        check_val("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_val("latency", 64'(edges), ed ? 64'd0 : 64'(WIDTH + 1));
            check_val("busy_with_done", 64'(busy), 64'd0);
            check_val("hi", 64'(hi), 64'(eh));
            check_val("lo", 64'(lo), 64'(el));
            check_val("div_by_zero", 64'(div_by_zero), 64'(ed));
            @(negedge clock);
            check_val("done_pulse_width", 64'(done), 64'd0);
            check_val("hi_after_done", 64'(hi), 64'(eh));
        end
    endtask

    // Asynchronous clear ten edges into an operation
    task automatic clear_mid_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bit saw_done;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2 clear = 1'b0;
        #1;
        check_val("clr_busy", 64'(busy), 64'd0);
        check_val("clr_done", 64'(done), 64'd0);
        check_val("clr_hi", 64'(hi), 64'd0);
        check_val("clr_lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        clear = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        check_val("clr_no_done", 64'(saw_done), 64'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clear = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        check_val("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        clear = 1'b1;

        // Directed cases
        run_op(2'b10, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'hFFFF_FFEF, 32'd5, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h12, 32'd0, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'd17, 32'hFFFF_FFFB, 1'b0);
        run_op(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Clear mid-operation, then a fresh operation must complete
        clear_mid_op(2'b10, 32'h0000_1234, 32'h0000_5678);
        run_op(2'b11, 32'hFFFF_FF9C, 32'd9, 1'b0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          mode;
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            mode = int'($urandom_range(0, 9));
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (mode == 2) begin
                ra = 32'($urandom_range(0, 40)) - 32'd20;
                rb = 32'($urandom_range(0, 10)) - 32'd5;
            end
            run_op(ro, ra, rb, (k % 7) == 3);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
